// File: rtl/tf_gen_lanes.sv
// Twiddle-factor generator: LANES lanes each emit seed_l * step^k mod MOD for k = 0..num-1
// over a valid/ready stream. One bit-serial interleaved modular multiplier per lane.
// Build option TF_GEN_RADIX4_MUL_EN: consume two step bits per multiply cycle (DW/2 cycles).
module tf_gen_lanes #(
  parameter int unsigned   DW    = 256,
  parameter int unsigned   LANES = 4,
  parameter int unsigned   CNT_W = 8,
  parameter logic [DW-1:0] MOD   =
    256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [LANES*DW-1:0]   seed_i,
  input  logic [DW-1:0]         step_i,
  input  logic [CNT_W-1:0]      num_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   tf_o,
  output logic [CNT_W-1:0]      out_idx,
  output logic                  busy,
  output logic                  done
);

`ifdef TF_GEN_RADIX4_MUL_EN
  localparam int unsigned MulCyc = DW / 2;
  localparam int unsigned ShAmt  = 2;
  if ((DW % 2) != 0) begin : g_dw_odd
    $error("tf_gen_lanes: DW must be even for radix-4 multiplication");
  end
`else
  localparam int unsigned MulCyc = DW;
  localparam int unsigned ShAmt  = 1;
`endif
  localparam int unsigned    BW      = (MulCyc > 1) ? $clog2(MulCyc) : 1;
  localparam logic [BW-1:0]  BitLast = BW'(MulCyc - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StEmit = 2'd1;
  localparam logic [1:0] StMul  = 2'd2;

  // (a + b) mod MOD for a, b < MOD: one DW+1-bit add and a single conditional subtract.
  function automatic logic [DW-1:0] f_mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, MOD}) s = s - {1'b0, MOD};
    return s[DW-1:0];
  endfunction

  logic [1:0]       r_state;
  logic [DW-1:0]    r_cur [LANES];
  logic [DW-1:0]    r_acc [LANES];
  logic [DW-1:0]    r_step;
  logic [DW-1:0]    r_sh;      // step copy shifted left so the active bit(s) sit at the MSB
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_idx;
  logic [BW-1:0]    r_cnt;
  logic             r_done;

  logic [DW-1:0]    w_dbl     [LANES];
  logic [DW-1:0]    w_add     [LANES];
  logic [DW-1:0]    w_acc_nxt [LANES];
`ifdef TF_GEN_RADIX4_MUL_EN
  logic [DW-1:0]    w_cur2    [LANES];
  logic [DW-1:0]    w_cur3    [LANES];
`endif

  // One multiplier step per lane: shift accumulator, then add the selected multiple of cur.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
`ifdef TF_GEN_RADIX4_MUL_EN
      // cur is constant for the whole multiply, so 2*cur and 3*cur act as precomputed terms.
      w_cur2[l] = f_mod_add(r_cur[l], r_cur[l]);
      w_cur3[l] = f_mod_add(w_cur2[l], r_cur[l]);
      w_dbl[l]  = f_mod_add(r_acc[l], r_acc[l]);
      w_dbl[l]  = f_mod_add(w_dbl[l], w_dbl[l]);
      case (r_sh[DW-1 -: 2])
        2'd1:    w_add[l] = r_cur[l];
        2'd2:    w_add[l] = w_cur2[l];
        2'd3:    w_add[l] = w_cur3[l];
        default: w_add[l] = '0;
      endcase
`else
      w_dbl[l] = f_mod_add(r_acc[l], r_acc[l]);
      w_add[l] = r_sh[DW-1] ? r_cur[l] : '0;
`endif
      w_acc_nxt[l] = f_mod_add(w_dbl[l], w_add[l]);
    end
  end

  // Control FSM and datapath registers; reset wins at every edge and discards any partial product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_step  <= '0;
      r_sh    <= '0;
      r_num   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        r_cur[l] <= '0;
        r_acc[l] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (cfg_valid) begin
            for (int l = 0; l < LANES; l++) r_cur[l] <= seed_i[l*DW +: DW];
            r_step <= step_i;
            r_num  <= num_i;
            r_idx  <= '0;
            if (num_i == '0) r_done  <= 1'b1;
            else             r_state <= StEmit;
          end
        end
        StEmit: begin
          if (out_ready) begin
            if (r_idx == r_num - CNT_W'(1)) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end else begin
              r_state <= StMul;
              r_cnt   <= BitLast;
              r_sh    <= r_step;
              for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
            end
          end
        end
        StMul: begin
          r_sh <= r_sh << ShAmt;
          for (int l = 0; l < LANES; l++) r_acc[l] <= w_acc_nxt[l];
          if (r_cnt == '0) begin
            for (int l = 0; l < LANES; l++) r_cur[l] <= w_acc_nxt[l];
            r_idx   <= r_idx + CNT_W'(1);
            r_state <= StEmit;
          end else begin
            r_cnt <= r_cnt - BW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Output decode straight from state and registers.
  always_comb begin
    cfg_ready = (r_state == StIdle);
    busy      = (r_state != StIdle);
    out_valid = (r_state == StEmit);
    out_idx   = r_idx;
    done      = r_done;
    tf_o      = '0;
    for (int l = 0; l < LANES; l++) tf_o[l*DW +: DW] = r_cur[l];
  end

endmodule

// File: tb/tb_tf_gen_lanes.sv
// Bench for tf_gen_lanes: a small instance (DW=8, MOD=251, 2 lanes) and a default-size one.
// Expected elements come from a reference modular multiply and are checked by stream monitors.
module tb_tf_gen_lanes;
  localparam int unsigned SDW = 8;
  localparam int unsigned SL  = 2;
  localparam logic [7:0]  SMOD = 8'd251;
  localparam int unsigned BDW = 256;
  localparam int unsigned BL  = 4;
  localparam logic [255:0] BMOD =
    256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
`ifdef TF_GEN_RADIX4_MUL_EN
  localparam int SGAP = SDW / 2 + 1;
  localparam int BGAP = BDW / 2 + 1;
`else
  localparam int SGAP = SDW + 1;
  localparam int BGAP = BDW + 1;
`endif

  typedef struct packed { logic [7:0] idx; logic [SL*SDW-1:0] tf; } exp_s_t;
  typedef struct packed { logic [7:0] idx; logic [BL*BDW-1:0] tf; } exp_b_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               s_cfg_valid = 1'b0, s_cfg_ready, s_out_valid, s_out_ready = 1'b0;
  logic               s_busy, s_done;
  logic [SL*SDW-1:0]  s_seed = '0, s_tf;
  logic [SDW-1:0]     s_step = '0;
  logic [7:0]         s_num = '0, s_idx;

  logic               b_cfg_valid = 1'b0, b_cfg_ready, b_out_valid, b_out_ready = 1'b0;
  logic               b_busy, b_done;
  logic [BL*BDW-1:0]  b_seed = '0, b_tf;
  logic [BDW-1:0]     b_step = '0;
  logic [7:0]         b_num = '0, b_idx;

  int n_checks = 0;
  int n_errors = 0;
  exp_s_t q_s[$];
  exp_b_t q_b[$];

  tf_gen_lanes #(.DW(SDW), .LANES(SL), .CNT_W(8), .MOD(SMOD)) u_small (
    .clk(clk), .rst(rst), .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready), .seed_i(s_seed),
    .step_i(s_step), .num_i(s_num), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .tf_o(s_tf), .out_idx(s_idx), .busy(s_busy), .done(s_done)
  );

  tf_gen_lanes #(.DW(BDW), .LANES(BL), .CNT_W(8), .MOD(BMOD)) u_big (
    .clk(clk), .rst(rst), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .seed_i(b_seed),
    .step_i(b_step), .num_i(b_num), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .tf_o(b_tf), .out_idx(b_idx), .busy(b_busy), .done(b_done)
  );

  // Inputs at or above MOD give undefined results; flag any such configuration.
  always @(posedge clk) begin
    if (!rst && s_cfg_valid && s_cfg_ready)
      assert (s_step < SMOD && s_seed[7:0] < SMOD && s_seed[15:8] < SMOD)
        else $error("small instance configured with operand >= MOD");
    if (!rst && b_cfg_valid && b_cfg_ready)
      assert (b_step < BMOD && b_seed[255:0] < BMOD && b_seed[511:256] < BMOD &&
              b_seed[767:512] < BMOD && b_seed[1023:768] < BMOD)
        else $error("big instance configured with operand >= MOD");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] mm8(input logic [7:0] a, input logic [7:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return 8'(p % 251);
  endfunction

  function automatic logic [255:0] mm256(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] p;
    p = {256'b0, a} * {256'b0, b};
    p = p % {256'b0, BMOD};
    return p[255:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one config cycle and queue the expected element stream.
  task automatic cfg_s(input logic [15:0] seeds, input logic [7:0] step, input logic [7:0] num);
    logic [7:0] cur [SL];
    exp_s_t e;
    for (int l = 0; l < SL; l++) cur[l] = seeds[l*8 +: 8];
    for (int k = 0; k < int'(num); k++) begin
      e.idx = 8'(k);
      for (int l = 0; l < SL; l++) e.tf[l*8 +: 8] = cur[l];
      q_s.push_back(e);
      for (int l = 0; l < SL; l++) cur[l] = mm8(cur[l], step);
    end
    s_seed = seeds; s_step = step; s_num = num; s_cfg_valid = 1'b1;
    tick();
    s_cfg_valid = 1'b0;
  endtask

  task automatic cfg_b(input logic [1023:0] seeds, input logic [255:0] step, input logic [7:0] num);
    logic [255:0] cur [BL];
    exp_b_t e;
    for (int l = 0; l < BL; l++) cur[l] = seeds[l*256 +: 256];
    for (int k = 0; k < int'(num); k++) begin
      e.idx = 8'(k);
      for (int l = 0; l < BL; l++) e.tf[l*256 +: 256] = cur[l];
      q_b.push_back(e);
      for (int l = 0; l < BL; l++) cur[l] = mm256(cur[l], step);
    end
    b_seed = seeds; b_step = step; b_num = num; b_cfg_valid = 1'b1;
    tick();
    b_cfg_valid = 1'b0;
  endtask

  // Returns extra cycles waited until out_valid, or -1 when the bound expires.
  task automatic wait_s_valid(input int max, output int n);
    n = 0;
    while (!s_out_valid && n < max) begin tick(); n++; end
    if (!s_out_valid) n = -1;
  endtask

  task automatic wait_b_valid(input int max, output int n);
    n = 0;
    while (!b_out_valid && n < max) begin tick(); n++; end
    if (!b_out_valid) n = -1;
  endtask

  task automatic monitor_s();
    exp_s_t e;
    forever begin
      @(negedge clk);
      if (s_out_valid && s_out_ready) begin
        n_checks++;
        if (q_s.size() == 0) begin
          n_errors++;
          $display("FAIL s_unexpected: idx=%0d tf=%h, required no output", s_idx, s_tf);
        end else begin
          e = q_s.pop_front();
          if (s_idx !== e.idx || s_tf !== e.tf) begin
            n_errors++;
            $display("FAIL s_element: idx=%0d tf=%h, required idx=%0d tf=%h",
                     s_idx, s_tf, e.idx, e.tf);
          end
        end
        for (int l = 0; l < SL; l++) begin
          n_checks++;
          if (s_tf[l*8 +: 8] >= SMOD) begin
            n_errors++;
            $display("FAIL s_range: lane%0d tf=%0d, required < %0d", l, s_tf[l*8 +: 8], SMOD);
          end
        end
      end
    end
  endtask

  task automatic monitor_b();
    exp_b_t e;
    forever begin
      @(negedge clk);
      if (b_out_valid && b_out_ready) begin
        n_checks++;
        if (q_b.size() == 0) begin
          n_errors++;
          $display("FAIL b_unexpected: idx=%0d, required no output", b_idx);
        end else begin
          e = q_b.pop_front();
          if (b_idx !== e.idx || b_tf !== e.tf) begin
            n_errors++;
            $display("FAIL b_element: idx=%0d lane0=%h, required idx=%0d lane0=%h",
                     b_idx, b_tf[255:0], e.idx, e.tf[255:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (s_out_valid !== 1'b0 || s_tf !== '0 || s_idx !== '0 || s_busy !== 1'b0 ||
        s_done !== 1'b0 || s_cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_small: valid=%b tf=%h idx=%0d busy=%b done=%b rdy=%b, required 0,0,0,0,0,1",
               s_out_valid, s_tf, s_idx, s_busy, s_done, s_cfg_ready);
    end
    n_checks++;
    if (b_out_valid !== 1'b0 || b_tf !== '0 || b_idx !== '0 || b_busy !== 1'b0 ||
        b_done !== 1'b0 || b_cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_big: valid=%b idx=%0d busy=%b done=%b rdy=%b, required 0,0,0,0,1",
               b_out_valid, b_idx, b_busy, b_done, b_cfg_ready);
    end
  endtask

  // Seeds {3,5}, step 2, num 4: checks stream timing and the done pulse.
  task automatic test_basic();
    int n;
    s_out_ready = 1'b1;
    cfg_s(16'h0503, 8'd2, 8'd4);
    n_checks++;
    if (s_out_valid !== 1'b1 || s_busy !== 1'b1 || s_cfg_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_first_valid: valid=%b busy=%b rdy=%b, required 1,1,0",
               s_out_valid, s_busy, s_cfg_ready);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      wait_s_valid(SGAP + 4, n);
      n_checks++;
      if (n + 1 != SGAP) begin
        n_errors++;
        $display("FAIL basic_gap%0d: got %0d cycles, required %0d", k, n + 1, SGAP);
      end
    end
    tick();
    n_checks++;
    if (s_done !== 1'b1 || s_out_valid !== 1'b0 || s_cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_done: done=%b valid=%b rdy=%b, required 1,0,1",
               s_done, s_out_valid, s_cfg_ready);
    end
    tick();
    n_checks++;
    if (s_done !== 1'b0 || q_s.size() != 0) begin
      n_errors++;
      $display("FAIL basic_done_width: done=%b pending=%0d, required 0,0", s_done, q_s.size());
    end
  endtask

  // Seed 200 with step 3 forces modular wrap (200, 98, 43).
  task automatic test_wrap();
    int n;
    s_out_ready = 1'b1;
    cfg_s(16'hFAC8, 8'd3, 8'd3);
    n_checks++;
    if (s_tf[7:0] !== 8'd200) begin
      n_errors++;
      $display("FAIL wrap_first: got %0d, required 200", s_tf[7:0]);
    end
    for (int k = 1; k < 3; k++) begin
      tick();
      wait_s_valid(SGAP + 4, n);
      n_checks++;
      if (n < 0) begin
        n_errors++;
        $display("FAIL wrap_timeout%0d: got no valid, required valid", k);
      end
    end
    n_checks++;
    if (s_tf[7:0] !== 8'd43) begin
      n_errors++;
      $display("FAIL wrap_last: got %0d, required 43", s_tf[7:0]);
    end
    tick();
    n_checks++;
    if (s_done !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_done: got %b, required 1", s_done);
    end
    tick();
  endtask

  task automatic test_num_zero();
    cfg_s(16'h0102, 8'd7, 8'd0);
    n_checks++;
    if (s_done !== 1'b1 || s_out_valid !== 1'b0 || s_cfg_ready !== 1'b1 || s_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_done: done=%b valid=%b rdy=%b busy=%b, required 1,0,1,0",
               s_done, s_out_valid, s_cfg_ready, s_busy);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (s_done !== 1'b0 || s_out_valid !== 1'b0 || s_cfg_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL zero_idle%0d: done=%b valid=%b rdy=%b, required 0,0,1",
                 c, s_done, s_out_valid, s_cfg_ready);
      end
    end
  endtask

  // Stall element 1 for 5 cycles and poke cfg_valid while busy.
  task automatic test_backpressure();
    int n;
    logic [15:0] hold_tf;
    logic [7:0]  hold_idx;
    s_out_ready = 1'b1;
    cfg_s(16'h1109, 8'd5, 8'd3);
    tick();
    s_out_ready = 1'b0;
    wait_s_valid(SGAP + 4, n);
    hold_tf = s_tf;
    hold_idx = s_idx;
    n_checks++;
    if (n < 0 || hold_idx !== 8'd1) begin
      n_errors++;
      $display("FAIL bp_idx: got idx=%0d wait=%0d, required idx=1", hold_idx, n);
    end
    for (int c = 0; c < 5; c++) begin
      s_cfg_valid = (c == 2);
      s_seed = 16'h4040; s_num = 8'd1;
      n_checks++;
      if (s_cfg_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_cfg_ready%0d: got %b, required 0", c, s_cfg_ready);
      end
      tick();
      n_checks++;
      if (s_out_valid !== 1'b1 || s_tf !== hold_tf || s_idx !== hold_idx) begin
        n_errors++;
        $display("FAIL bp_hold%0d: valid=%b tf=%h idx=%0d, required 1 %h %0d",
                 c, s_out_valid, s_tf, s_idx, hold_tf, hold_idx);
      end
    end
    s_cfg_valid = 1'b0;
    s_out_ready = 1'b1;
    tick();
    wait_s_valid(SGAP + 4, n);
    n_checks++;
    if (n + 1 != SGAP) begin
      n_errors++;
      $display("FAIL bp_gap: got %0d cycles, required %0d", n + 1, SGAP);
    end
    tick();
    n_checks++;
    if (s_done !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_done: got %b, required 1", s_done);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (s_out_valid !== 1'b0 || q_s.size() != 0) begin
        n_errors++;
        $display("FAIL bp_no_extra%0d: valid=%b pending=%0d, required 0,0",
                 c, s_out_valid, q_s.size());
      end
    end
  endtask

  // Reset during the 4th multiply cycle, then rerun the basic sequence.
  task automatic test_reset_mid_mul();
    s_out_ready = 1'b1;
    cfg_s(16'h0503, 8'd2, 8'd4);
    tick();
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_s.delete();
    n_checks++;
    if (s_out_valid !== 1'b0 || s_tf !== '0 || s_busy !== 1'b0 || s_cfg_ready !== 1'b1 ||
        s_done !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_rst: valid=%b tf=%h busy=%b rdy=%b done=%b, required 0,0,0,1,0",
               s_out_valid, s_tf, s_busy, s_cfg_ready, s_done);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (s_done !== 1'b0 || s_out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL mid_rst_quiet%0d: done=%b valid=%b, required 0,0", c, s_done, s_out_valid);
      end
    end
    test_basic();
  endtask

  // New config accepted in the same cycle as the done pulse.
  task automatic test_back_to_back();
    int n;
    s_out_ready = 1'b1;
    cfg_s(16'h0B07, 8'd4, 8'd2);
    tick();
    wait_s_valid(SGAP + 4, n);
    tick();
    n_checks++;
    if (s_done !== 1'b1 || s_cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_done: done=%b rdy=%b, required 1,1", s_done, s_cfg_ready);
    end
    cfg_s(16'h2113, 8'd9, 8'd2);
    n_checks++;
    if (s_out_valid !== 1'b1 || s_done !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_accept: valid=%b done=%b, required 1,0", s_out_valid, s_done);
    end
    tick();
    wait_s_valid(SGAP + 4, n);
    tick();
    n_checks++;
    if (s_done !== 1'b1 || q_s.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_done2: done=%b pending=%0d, required 1,0", s_done, q_s.size());
    end
    tick();
  endtask

  // Default size: step = MOD-1 alternates 5, MOD-5 on lane 0.
  task automatic test_big();
    int n;
    b_out_ready = 1'b1;
    cfg_b({256'h1234_5678_9abc_def0, BMOD - 256'd1, 256'd1, 256'd5}, BMOD - 256'd1, 8'd4);
    n_checks++;
    if (b_out_valid !== 1'b1 || b_tf[255:0] !== 256'd5) begin
      n_errors++;
      $display("FAIL big_first: valid=%b lane0=%h, required 1, 5", b_out_valid, b_tf[255:0]);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      wait_b_valid(BGAP + 4, n);
      n_checks++;
      if (n + 1 != BGAP) begin
        n_errors++;
        $display("FAIL big_gap%0d: got %0d cycles, required %0d", k, n + 1, BGAP);
      end
      n_checks++;
      if (b_tf[255:0] !== (((k % 2) == 1) ? BMOD - 256'd5 : 256'd5)) begin
        n_errors++;
        $display("FAIL big_lane0_%0d: got %h", k, b_tf[255:0]);
      end
    end
    tick();
    n_checks++;
    if (b_done !== 1'b1 || q_b.size() != 0) begin
      n_errors++;
      $display("FAIL big_done: done=%b pending=%0d, required 1,0", b_done, q_b.size());
    end
    tick();
  endtask

  initial begin
    fork
      monitor_s();
      monitor_b();
    join_none
    test_reset();
    test_basic();
    test_wrap();
    test_num_zero();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_big();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
